ofdm_symbol_mapper_ctrl: RTL

// Sequences the 16-QAM subcarrier mapper (qam16_mod, instantiated inside) to build complete OFDM symbols.

---
 rtl/ofdm_symbol_mapper_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ofdm_symbol_mapper_ctrl.sv
// OFDM symbol mapper: walks subcarriers 0..N_FFT-1 emitting nulls,
// BPSK pilots or 16-QAM data from a byte stream, padding the last symbol.
module qam16_mod #(
    parameter int fft_depth = 12,
    parameter int levels_0  = 400,
    parameter int levels_1  = 1200
) (
    input  logic [3:0]           bits,
    output logic [fft_depth-1:0] i,
    output logic [fft_depth-1:0] q
);
    localparam logic [fft_depth-1:0] P0 = fft_depth'(levels_0);
    localparam logic [fft_depth-1:0] N0 = fft_depth'(-levels_0);
    localparam logic [fft_depth-1:0] P1 = fft_depth'(levels_1);
    localparam logic [fft_depth-1:0] N1 = fft_depth'(-levels_1);

    // Gray-coded axis: 00 -3, 01 -1, 11 +1, 10 +3
    function automatic logic [fft_depth-1:0] lvl(input logic [1:0] b);
        logic [fft_depth-1:0] r;
        unique case (b)
            2'b00:   r = N1;
            2'b01:   r = N0;
            2'b11:   r = P0;
            default: r = P1;
        endcase
        return r;
    endfunction

    assign i = lvl(bits[1:0]);
    assign q = lvl(bits[3:2]);
endmodule

module ofdm_symbol_mapper_ctrl #(
    parameter int N_FFT       = 64,
    parameter int N_USED      = 26,
    parameter int PILOT_SPACE = 8,
    parameter int fft_depth   = 12,
    parameter int levels_0    = 400,
    parameter int levels_1    = 1200
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic [fft_depth-1:0]     m_i,
    output logic [fft_depth-1:0]     m_q,
    output logic [$clog2(N_FFT)-1:0] m_idx,
    output logic                     m_valid,
    output logic                     m_last,
    input  logic                     m_ready,
    output logic                     busy,
    output logic [15:0]              sym_cnt
);
    localparam int KW = $clog2(N_FFT);
    localparam logic [fft_depth-1:0] P1 = fft_depth'(levels_1);
    localparam logic [fft_depth-1:0] N1 = fft_depth'(-levels_1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [KW-1:0]          k;
    logic                   nib_sel;
    logic                   pad;

    logic                   adv;
    logic                   is_null;
    logic                   is_pilot;
    logic                   is_data;
    logic                   producible;
    logic                   pop;
    logic                   pad_nx;
    logic                   k_last;
    logic [3:0]             nib;
    logic [fft_depth-1:0]   qi;
    logic [fft_depth-1:0]   qq;
    logic [fft_depth-1:0]   smp_i;
    logic [fft_depth-1:0]   smp_q;

    qam16_mod #(
        .fft_depth (fft_depth),
        .levels_0  (levels_0),
        .levels_1  (levels_1)
    ) u_qam (
        .bits (nib),
        .i    (qi),
        .q    (qq)
    );

    always_comb begin
        adv        = !m_valid || m_ready;
        is_null    = (k == '0) ||
                     (int'(k) > N_USED && int'(k) < N_FFT - N_USED);
        is_pilot   = !is_null && ((int'(k) % PILOT_SPACE) == 0);
        is_data    = !is_null && !is_pilot;
        producible = !is_data || pad || s_valid;
        nib        = pad ? 4'h0 : (nib_sel ? s_data[7:4] : s_data[3:0]);
        pop        = (state == RUN) && is_data && nib_sel && !pad &&
                     s_valid && adv;
        pad_nx     = pad || (pop && s_last);
        k_last     = (k == KW'(N_FFT - 1));
    end

    always_comb begin
        smp_i = qi;
        smp_q = qq;
        unique case (1'b1)
            is_null: begin
                smp_i = '0;
                smp_q = '0;
            end
            is_pilot: begin
                smp_i = sym_cnt[0] ? N1 : P1;
                smp_q = '0;
            end
            default: ;
        endcase
    end

    assign s_ready = pop;
    assign busy    = (state != IDLE) || m_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            nib_sel <= 1'b0;
            pad     <= 1'b0;
            sym_cnt <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_i     <= '0;
            m_q     <= '0;
            m_idx   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s_valid) begin
                        state   <= RUN;
                        k       <= '0;
                        nib_sel <= 1'b0;
                        pad     <= 1'b0;
                        sym_cnt <= '0;
                    end
                end
                RUN: begin
                    if (adv && producible) begin
                        m_valid <= 1'b1;
                        m_idx   <= k;
                        m_last  <= k_last;
                        m_i     <= smp_i;
                        m_q     <= smp_q;
                        pad     <= pad_nx;
                        if (is_data)
                            nib_sel <= !nib_sel;
                        if (k_last) begin
                            k       <= '0;
                            sym_cnt <= sym_cnt + 16'd1;
                            if (pad_nx)
                                state <= DONE;
                        end else begin
                            k <= k + KW'(1);
                        end
                    end else if (adv) begin
                        // starved for a byte: drop valid, hold index
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                    end
                end
                DONE: begin
                    if (adv) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
